mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Parametrised N-port arbiter that lets several memory-request masters (axi2mem instances, bootrom loaders, debug accessors) share one single-ported sram in the test harness, replacing the fixed one-bridge-per-memory arrangement. It selects one request per cycle (round-robin or fixed priority), forwards it combinationally to the memory, and tracks each accepted request through a configurable-latency pipeline so that the response valid is returned to the port that issued it. Writes are acknowledged through the same response path.

## Interface
- NrPorts, 2, number of requesting ports (>=1)
- AddrWidth, 64, address width
- DataWidth, 64, data width (multiple of 8)
- MemLatency, 1, cycles from accepted request to valid mem_rdata_i (>=1)
- FixedPrio, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  NrPorts  per-port request
- we_i  in  NrPorts  per-port write enable
- addr_i  in  NrPorts x AddrWidth  per-port address
- be_i  in  NrPorts x DataWidth/8  per-port byte enable
- wdata_i  in  NrPorts x DataWidth  per-port write data
- gnt_o  out  NrPorts  one-hot grant, same cycle as accepted req
- rvalid_o  out  NrPorts  one-hot response valid
- rdata_o  out  DataWidth  read data, shared by all ports, valid with rvalid_o
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  AddrWidth  memory address
- mem_be_o  out  DataWidth/8  memory byte enable
- mem_wdata_o  out  DataWidth  memory write data
- mem_rdata_i  in  DataWidth  memory read data, MemLatency cycles after mem_req_o

## Operation
- Memory is always ready: any cycle with at least one req_i bit set produces exactly one grant; mem_req_o = |req_i.
- Grant selection combinational from req_i and priority pointer ptr_q (width clog2(NrPorts), min 1).
- Round-robin: winner = first set req_i at index ptr_q, ptr_q+1, ... wrapping modulo NrPorts. On a grant to port k, ptr_q <= (k+1) mod NrPorts; no grant leaves ptr_q unchanged.
- FixedPrio=1: winner = lowest set index; ptr_q unused (held 0).
- mem_we_o/addr/be/wdata muxed from winner; when no request, driven to 0.
- Masters hold req_i and payload stable until gnt_o; arbiter does not check this.
- Response pipeline: MemLatency stages, each {valid, port index}. Stage 0 loaded with {mem_req_o, winner}; shift every cycle. Final stage valid v with index k drives rvalid_o[k]=1; all other bits 0.
- rdata_o = mem_rdata_i when any rvalid_o set, else 0. Write responses assert rvalid_o with rdata_o = mem_rdata_i (content don't-care).
- Pipeline is fully pipelined: one new grant per cycle, MemLatency responses in flight max; no back-pressure on responses.
- NrPorts=1: gnt_o = req_i, pointer logic collapses.

## Timing
- Reset: ptr_q=0, all pipeline valids 0; rvalid_o=0, rdata_o=0; gnt_o and mem_* follow req_i combinationally (0 when req_i=0).
- Grant latency 0 cycles (gnt_o same cycle as req_i when winning).
- Response latency exactly MemLatency cycles after grant cycle, e.g. MemLatency=1: grant at edge n, rvalid_o at cycle n+1.
- Back-to-back grants to different ports return in grant order, one per cycle.
- Simultaneous all-ports request: each port granted exactly once every NrPorts cycles in round-robin mode.
- Pointer wrap: grant to port NrPorts-1 sets ptr_q=0.
- Reset asserted mid-operation: in-flight responses discarded immediately (rvalid_o drops asynchronously); no response emitted after release for pre-reset grants.
- Fixed priority may starve higher indices; this is intended.

## Test plan
- NrPorts=3, MemLatency=1, RR: req_i=3'b111 held 6 cycles -> gnt_o sequence 001,010,100,001,010,100; rvalid_o same sequence delayed one cycle.
- Port1 write addr 0x8000_0000 data 0xDEAD_BEEF_0123_4567 be 0xFF, then port2 read same addr -> gnt both, port2 rvalid_o[2] with rdata_o=0xDEAD_BEEF_0123_4567; port1 gets rvalid_o[1] one cycle after its grant.
- MemLatency=3: grant port0 at cycle 10, port1 at 11 -> rvalid_o=001 at 13, 010 at 14, 0 elsewhere.
- FixedPrio=1, req_i=3'b110 held 4 cycles -> gnt_o=010 every cycle, port2 never granted.
- Pointer wrap: ptr_q=2 after grants, req_i=3'b011 -> grant port0, ptr_q becomes 1.
- MemLatency=2, grant at cycle 5, rst_ni low at cycle 6 for one cycle -> rvalid_o stays 0 through cycle 10; first post-reset grant goes to port0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Lets several memory-request masters share one single-ported sram. One request
// is granted per cycle (round-robin or fixed priority) and forwarded
// combinationally to the memory. Every accepted request is tracked through a
// MemLatency-deep pipeline of {valid, port index} so the response valid returns
// to the port that issued it. Writes are acknowledged the same way.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i, we_i          per-port request / write enable
//   addr_i, be_i,        per-port address, byte enable, write data
//   wdata_i
//   gnt_o                one-hot grant, same cycle as the accepted request
//   rvalid_o             one-hot response valid, MemLatency cycles after grant
//   rdata_o              shared read data, mem_rdata_i while rvalid_o != 0
//   mem_req_o .. mem_wdata_o  request forwarded to the memory (0 when idle)
//   mem_rdata_i          memory read data, MemLatency cycles after mem_req_o
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned NrPorts    = 2,
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned MemLatency = 1,
  parameter bit          FixedPrio  = 1'b0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NrPorts-1:0]                    req_i,
  input  logic [NrPorts-1:0]                    we_i,
  input  logic [NrPorts-1:0][AddrWidth-1:0]     addr_i,
  input  logic [NrPorts-1:0][DataWidth/8-1:0]   be_i,
  input  logic [NrPorts-1:0][DataWidth-1:0]     wdata_i,
  output logic [NrPorts-1:0]                    gnt_o,
  output logic [NrPorts-1:0]                    rvalid_o,
  output logic [DataWidth-1:0]                  rdata_o,
  output logic                                  mem_req_o,
  output logic                                  mem_we_o,
  output logic [AddrWidth-1:0]                  mem_addr_o,
  output logic [DataWidth/8-1:0]                mem_be_o,
  output logic [DataWidth-1:0]                  mem_wdata_o,
  input  logic [DataWidth-1:0]                  mem_rdata_i
);

  localparam int unsigned IdxWidth = (NrPorts > 1) ? $clog2(NrPorts) : 1;

  typedef logic [IdxWidth-1:0] idx_t;

  idx_t ptr_q;
  idx_t winner;
  idx_t cand;
  logic found;

  // Response pipeline: one {valid, port index} per memory latency cycle.
  logic [MemLatency-1:0]               valid_q;
  logic [MemLatency-1:0][IdxWidth-1:0] idx_q;

  // Winner search: walk the ports starting at the priority pointer (or at 0 in
  // fixed-priority mode) and take the first requester.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < NrPorts; i++) begin
      if (FixedPrio) cand = idx_t'(i);
      else           cand = idx_t'((32'(ptr_q) + i) % NrPorts);
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign mem_req_o = |req_i;

  always_comb begin
    gnt_o       = '0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (found) begin
      gnt_o[winner] = 1'b1;
      mem_we_o      = we_i[winner];
      mem_addr_o    = addr_i[winner];
      mem_be_o      = be_i[winner];
      mem_wdata_o   = wdata_i[winner];
    end
  end

  // Pointer moves just past the last winner; fixed priority keeps it at 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (!FixedPrio && found) begin
      ptr_q <= (winner == idx_t'(NrPorts - 1)) ? '0 : idx_t'(winner + 1'b1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: only the valids must be cleared to drop in-flight responses; the
      // index stages are cleared too so the rvalid decode never sees X.
      valid_q <= '0;
      idx_q   <= '0;
    end else begin
      valid_q[0] <= mem_req_o;
      idx_q[0]   <= winner;
      for (int unsigned i = 1; i < MemLatency; i++) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  // The last stage is decoded straight from flops, so reset clears rvalid_o
  // asynchronously.
  always_comb begin
    rvalid_o = '0;
    if (valid_q[MemLatency-1]) rvalid_o[idx_q[MemLatency-1]] = 1'b1;
  end

  assign rdata_o = (|rvalid_o) ? mem_rdata_i : '0;

endmodule
